// File: rtl/scratchpad_ram_mt.sv
// scratchpad_ram_mt: per-thread banked scrypt scratchpad with a tagged read handshake and an optional post-reset zero clear.
// Latency: READ_LATENCY (1 or 2) cycles from rden sample to q_valid; writes land on the accepting edge.
// Backpressure: none; any request presented while busy is high is dropped (no write, no q_valid).
module scratchpad_ram_mt #(
    parameter int WIDTH          = 256,
    parameter int ADDRBITS       = 10,
    parameter int THREADBITS     = 1,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [THREADBITS-1:0] thread,
    input  logic [ADDRBITS-1:0]   address,
    input  logic [WIDTH-1:0]      data,
    input  logic                  wren,
    input  logic                  rden,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [THREADBITS-1:0] q_thread,
    output logic                  busy
);
    localparam int IDXBITS = ADDRBITS + THREADBITS;
    localparam int DEPTH   = 1 << IDXBITS;
    localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDXBITS-1:0]   clear_ptr_q, clear_ptr_d;
    logic                 busy_q, busy_d;

    logic [IDXBITS-1:0]   req_idx;
    logic                 wr_acc, rd_acc;
    logic                 mem_we;
    logic [IDXBITS-1:0]   mem_wa;
    logic [WIDTH-1:0]     mem_wd;

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0]      rd_dat_q;
    logic                  rd_vld_q, rd_vld_d;
    logic [THREADBITS-1:0] rd_thr_q, rd_thr_d;

    // Clear sequencer: walk every index once, then park in READY; busy mirrors the next state.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        busy_d      = busy_q;
        if (state_q == CLEAR) begin
            if (clear_ptr_q == LAST_IDX) begin
                state_d = READY;
            end else begin
                clear_ptr_d = clear_ptr_q + IDXBITS'(1);
            end
        end
        busy_d = (state_d == CLEAR);
    end

    // Sequencer registers; reset always reports busy for at least one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= CLEAR;
            end else begin
                state_q <= READY;
            end
            clear_ptr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            busy_q      <= busy_d;
        end
    end

    // Request qualification and the single write port shared by the clear sequencer and user writes.
    always_comb begin
        req_idx = {thread, address};
        wr_acc  = wren & ~busy_q & ~reset;
        rd_acc  = rden & ~busy_q & ~reset;
        mem_we  = 1'b0;
        mem_wa  = req_idx;
        mem_wd  = data;
        if ((state_q == CLEAR) && !reset) begin
            mem_we = 1'b1;
            mem_wa = clear_ptr_q;
            mem_wd = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // Storage array write.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Write-first read register: snapshots the word on the issue edge so later writes cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_dat_q <= '0;
        end else if (rd_acc) begin
            rd_dat_q <= wr_acc ? data : mem[req_idx];
        end
    end

    // First-stage valid/tag tracking the read register.
    always_comb begin
        rd_vld_d = rd_acc;
        rd_thr_d = rd_acc ? thread : rd_thr_q;
    end

    // First-stage valid/tag registers; reset drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_thr_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_thr_q <= rd_thr_d;
        end
    end

    assign busy = busy_q;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign q        = rd_dat_q;
            assign q_valid  = rd_vld_q;
            assign q_thread = rd_thr_q;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0]      out_dat_q, out_dat_d;
            logic                  out_vld_q, out_vld_d;
            logic [THREADBITS-1:0] out_thr_q, out_thr_d;

            // Output stage copies a result only when the first stage holds a fresh one.
            always_comb begin
                out_vld_d = rd_vld_q;
                out_dat_d = rd_vld_q ? rd_dat_q : out_dat_q;
                out_thr_d = rd_vld_q ? rd_thr_q : out_thr_q;
            end

            // Output stage registers.
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_dat_q <= '0;
                    out_vld_q <= 1'b0;
                    out_thr_q <= '0;
                end else begin
                    out_dat_q <= out_dat_d;
                    out_vld_q <= out_vld_d;
                    out_thr_q <= out_thr_d;
                end
            end

            assign q        = out_dat_q;
            assign q_valid  = out_vld_q;
            assign q_thread = out_thr_q;
        end else begin : g_bad_latency
            $error("scratchpad_ram_mt: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule
